decoder_3x8_beh: RTL and testbench

//   3-to-8 line decoder with registered, one-hot outputs.

---
 rtl/decoder_3x8_beh.sv | 34 +++
 tb/tb_decoder_3x8_beh.sv | 100 ++++++++++
 2 files changed

// File: rtl/decoder_3x8_beh.sv
// decoder_3x8_beh: registered 3-to-8 one-hot decoder, index {c,a,b}.
// Define DECODER_3X8_ACTIVE_LOW_EN for active-low outputs (idle level 1, selected line 0).
module decoder_3x8_beh (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3,
    output logic q4,
    output logic q5,
    output logic q6,
    output logic q7
);
`ifdef DECODER_3X8_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE = 8'hff;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif
    logic [2:0] idx;
    logic [7:0] hot;
    logic [7:0] q;
    assign idx = {c, a, b};
    always_comb hot = en ? (8'b1 << idx) : 8'b0;
    // XOR with the idle level flips polarity without touching the decode itself
    always_ff @(posedge clk)
        if (rst) q <= IDLE;
        else     q <= hot ^ IDLE;
    assign {q7, q6, q5, q4, q3, q2, q1, q0} = q;
endmodule

// File: tb/tb_decoder_3x8_beh.sv
// tb_decoder_3x8_beh: directed and random checks of the registered 3-to-8 decoder.
// Expectations follow DECODER_3X8_ACTIVE_LOW_EN when it is defined.
module tb_decoder_3x8_beh;
`ifdef DECODER_3X8_ACTIVE_LOW_EN
    localparam logic [7:0] OFF = 8'hff;
`else
    localparam logic [7:0] OFF = 8'h00;
`endif
    logic clk = 1'b0;
    logic rst, en, a, b, c;
    logic q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0] qv;
    int tests = 0;
    int failed = 0;

    decoder_3x8_beh dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7)
    );

    always #5 clk = ~clk;
    assign qv = {q7, q6, q5, q4, q3, q2, q1, q0};

    task automatic chk(input string tag, input logic [7:0] act_hi);
        logic [7:0] exp;
        exp = act_hi ^ OFF;
        tests++;
        assert (qv === exp) else begin
            failed++;
            $error("FAIL %s: got %b expected %b", tag, qv, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic aa, input logic bb, input logic cc);
        rst = r; en = e; a = aa; b = bb; c = cc;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8] = '{8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000,
                                  8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000};
    logic [2:0] sweep_abc [8] = '{3'b000, 3'b010, 3'b100, 3'b110,
                                  3'b001, 3'b011, 3'b101, 3'b111};

    initial begin
        rst = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
        // reset with en=1 and {c,a,b}=101 must still clear
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        chk("reset", 8'h00);

        // sweep, table given as {a,b,c}
        for (int i = 0; i < 8; i++) begin
            step(0, 1, sweep_abc[i][2], sweep_abc[i][1], sweep_abc[i][0]);
            chk($sformatf("sweep_%0d", i), sweep_exp[i]);
        end

        step(0, 0, 1, 1, 1);
        chk("en_off", 8'h00);
        step(0, 1, 1, 1, 1);
        chk("en_on_q7", 8'h80);

        // selects changing between edges must not reach the outputs
        step(0, 1, 1, 1, 0);
        chk("lat_q3", 8'h08);
        a = 1'b0; b = 1'b0; c = 1'b1; en = 1'b1;
        #2 chk("lat_hold_a", 8'h08);
        a = 1'b1; b = 1'b0; c = 1'b1;
        #2 chk("lat_hold_b", 8'h08);
        @(posedge clk); #1;
        chk("lat_q6", 8'h40);

        step(0, 1, 0, 1, 1);
        chk("mid_q5", 8'h20);
        step(1, 1, 0, 1, 1);
        chk("mid_rst", 8'h00);
        step(0, 1, 0, 1, 1);
        chk("mid_resume_q5", 8'h20);

        // random one-hot check: expected line computed from what was driven
        for (int i = 0; i < 1000; i++) begin
            logic r, e, aa, bb, cc;
            logic [7:0] act;
            r  = ($urandom_range(0, 15) == 0);
            e  = 1'($urandom);
            aa = 1'($urandom); bb = 1'($urandom); cc = 1'($urandom);
            step(r, e, aa, bb, cc);
            act = qv ^ OFF;
            tests++;
            assert ($countones(act) <= 1) else begin
                failed++;
                $error("FAIL rand_onehot_%0d: got %b expected popcount<=1", i, qv);
            end
            chk($sformatf("rand_%0d", i), (!r && e) ? (8'b1 << {cc, aa, bb}) : 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
